// File: rtl/clk_ratio_meter.sv
`default_nettype none
// ============================================================================
//  Module      : clk_ratio_meter
//  Description : Measures a slow divided clock against the reference clock:
//                period, high time, 50% duty flag, ratio lock and timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_ratio_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CNT    = 4,
    parameter int TOL         = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clk_div,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_even,
    output logic             o_valid,
    output logic             o_locked,
    output logic             o_timeout
);

    localparam int               LCW           = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_TO      = C_CNT_MAX - 1'b1;
    localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_TOL         = CNT_W'(TOL);
    localparam logic [LCW-1:0]   C_LOCK_MAX    = LCW'(LOCK_CNT);
    localparam logic [LCW-1:0]   C_LOCK_ONE    = LCW'(1);
    localparam logic             C_LOCK_AT_ONE = (LOCK_CNT == 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_TRACK = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_sync;
    logic                   w_rise;
    logic                   w_fall;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_hcnt;
    logic [LCW-1:0]         r_lock_cnt;
    logic [LCW-1:0]         w_lock_nxt;
    logic [LCW-1:0]         w_lock_inc;
    logic [CNT_W-1:0]       w_diff;
    logic                   w_match;
    logic                   w_cnt_to;
    logic                   w_measure;
    logic                   w_valid_nxt;
    logic                   w_locked_nxt;
    logic                   w_timeout_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_clk_div};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_prev;
    assign w_fall = ~w_sync & r_prev;

    // r_cnt holds the cycles elapsed since the last rise, saturating.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_hcnt <= '0;
        end else begin
            if (w_rise) begin
                r_cnt <= C_CNT_ONE;
            end else if (r_cnt != C_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_fall) begin
                r_hcnt <= r_cnt;
            end
        end
    end

    // Timeout fires on the edge where the counter lands on its ceiling.
    assign w_cnt_to   = (r_cnt == C_CNT_TO);
    assign w_diff     = (r_cnt >= o_period) ? (r_cnt - o_period) : (o_period - r_cnt);
    assign w_match    = (w_diff <= C_TOL);
    assign w_lock_inc = (r_lock_cnt >= C_LOCK_MAX) ? C_LOCK_MAX : (r_lock_cnt + C_LOCK_ONE);

    always_comb begin
        w_state_nxt   = r_state;
        w_lock_nxt    = r_lock_cnt;
        w_locked_nxt  = o_locked;
        w_timeout_nxt = o_timeout;
        w_measure     = 1'b0;
        w_valid_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nxt   = S_ARMED;
                    w_timeout_nxt = 1'b0;
                end
            end
            S_ARMED: begin
                if (w_rise) begin
                    w_measure    = 1'b1;
                    w_lock_nxt   = C_LOCK_ONE;
                    w_locked_nxt = C_LOCK_AT_ONE;
                    w_state_nxt  = S_TRACK;
                end else if (w_cnt_to) begin
                    w_timeout_nxt = 1'b1;
                    w_locked_nxt  = 1'b0;
                    w_lock_nxt    = '0;
                    w_state_nxt   = S_IDLE;
                end
            end
            S_TRACK: begin
                if (w_rise) begin
                    w_measure = 1'b1;
                    if (w_match) begin
                        w_lock_nxt   = w_lock_inc;
                        w_locked_nxt = (w_lock_inc == C_LOCK_MAX);
                    end else begin
                        w_lock_nxt   = C_LOCK_ONE;
                        w_locked_nxt = 1'b0;
                    end
                end else if (w_cnt_to) begin
                    w_timeout_nxt = 1'b1;
                    w_locked_nxt  = 1'b0;
                    w_lock_nxt    = '0;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_measure) begin
            w_valid_nxt   = 1'b1;
            w_timeout_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_lock_cnt <= '0;
            o_period   <= '0;
            o_high     <= '0;
            o_even     <= 1'b0;
            o_valid    <= 1'b0;
            o_locked   <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_nxt;
            o_valid    <= w_valid_nxt;
            o_locked   <= w_locked_nxt;
            o_timeout  <= w_timeout_nxt;
            if (w_measure) begin
                o_period <= r_cnt;
                o_high   <= r_hcnt;
                // Widened by one bit so doubling the high time cannot wrap.
                o_even   <= ({r_hcnt, 1'b0} == {1'b0, r_cnt});
            end
        end
    end

endmodule
`default_nettype wire
